// File: rtl/hazard_fwd_unit_if.sv
// Decode/EX/WB hazard bundle between the pipeline and the forwarding unit.
// HAZARD_PERF_EN adds the stall/flush event counters.
interface hazard_fwd_unit_if #(
    parameter int D = 32,
    parameter int R = 5
);
    logic         dec_valid_i;
    logic [R-1:0] dec_rs_addr_i;
    logic [R-1:0] dec_rt_addr_i;
    logic [D-1:0] dec_rs_i;
    logic [D-1:0] dec_rt_i;
    logic         ex_valid_i;
    logic         ex_we_i;
    logic         ex_is_load_i;
    logic [R-1:0] ex_rd_i;
    logic [D-1:0] ex_result_i;
    logic         wb_valid_i;
    logic         wb_we_i;
    logic [R-1:0] wb_rd_i;
    logic [D-1:0] wb_result_i;
    logic         branch_taken_i;
    logic [D-1:0] rs_o;
    logic [D-1:0] rt_o;
    logic [1:0]   fwd_rs_sel_o;
    logic [1:0]   fwd_rt_sel_o;
    logic         stall_o;
    logic         flush_o;
`ifdef HAZARD_PERF_EN
    logic [15:0]  stall_cnt_o;
    logic [15:0]  flush_cnt_o;
`endif

    modport master (
        output dec_valid_i, dec_rs_addr_i, dec_rt_addr_i,
        output dec_rs_i, dec_rt_i,
        output ex_valid_i, ex_we_i, ex_is_load_i,
        output ex_rd_i, ex_result_i,
        output wb_valid_i, wb_we_i, wb_rd_i, wb_result_i,
        output branch_taken_i,
`ifdef HAZARD_PERF_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        input  rs_o, rt_o, fwd_rs_sel_o, fwd_rt_sel_o,
        input  stall_o, flush_o
    );

    modport slave (
        input  dec_valid_i, dec_rs_addr_i, dec_rt_addr_i,
        input  dec_rs_i, dec_rt_i,
        input  ex_valid_i, ex_we_i, ex_is_load_i,
        input  ex_rd_i, ex_result_i,
        input  wb_valid_i, wb_we_i, wb_rd_i, wb_result_i,
        input  branch_taken_i,
`ifdef HAZARD_PERF_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        output rs_o, rt_o, fwd_rs_sel_o, fwd_rt_sel_o,
        output stall_o, flush_o
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding (EX > WB > history > regfile), load-use stall, branch flush.
// HAZARD_PERF_EN enables saturating stall/flush event counters.
module hazard_fwd_unit #(
    parameter int D = 32,
    parameter int R = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    hazard_fwd_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STALL, FLUSH1, FLUSH2} state_t;

    state_t       state;
    state_t       nxt;
    logic         flush_q;
    logic         hist_v;
    logic [R-1:0] hist_rd;
    logic [D-1:0] hist_data;

    logic ex_src, wb_src;
    logic rs_nz, rt_nz;
    logic rs_ex, rt_ex, rs_wb, rt_wb, rs_h, rt_h;
    logic load_use, stall;

    assign ex_src = bus.ex_valid_i & bus.ex_we_i;
    assign wb_src = bus.wb_valid_i & bus.wb_we_i;
    assign rs_nz  = |bus.dec_rs_addr_i;
    assign rt_nz  = |bus.dec_rt_addr_i;

    assign rs_ex = rs_nz & ex_src & (bus.ex_rd_i == bus.dec_rs_addr_i);
    assign rt_ex = rt_nz & ex_src & (bus.ex_rd_i == bus.dec_rt_addr_i);
    assign rs_wb = rs_nz & wb_src & (bus.wb_rd_i == bus.dec_rs_addr_i);
    assign rt_wb = rt_nz & wb_src & (bus.wb_rd_i == bus.dec_rt_addr_i);
    assign rs_h  = rs_nz & hist_v & (hist_rd == bus.dec_rs_addr_i);
    assign rt_h  = rt_nz & hist_v & (hist_rd == bus.dec_rt_addr_i);

    // A load still in EX has no data yet; the stalled cycle picks it up from WB.
    assign load_use = bus.dec_valid_i & bus.ex_is_load_i & (rs_ex | rt_ex);

    assign stall = rst_ni & (state == IDLE) & load_use & ~bus.branch_taken_i;
    assign bus.stall_o = stall;
    assign bus.flush_o = flush_q;

    always_comb begin
        bus.rs_o = bus.dec_rs_i;
        bus.fwd_rs_sel_o = 2'd0;
        if (rs_ex && !bus.ex_is_load_i) begin
            bus.rs_o = bus.ex_result_i;
            bus.fwd_rs_sel_o = 2'd1;
        end else if (rs_wb) begin
            bus.rs_o = bus.wb_result_i;
            bus.fwd_rs_sel_o = 2'd2;
        end else if (rs_h) begin
            bus.rs_o = hist_data;
            bus.fwd_rs_sel_o = 2'd3;
        end
    end

    always_comb begin
        bus.rt_o = bus.dec_rt_i;
        bus.fwd_rt_sel_o = 2'd0;
        if (rt_ex && !bus.ex_is_load_i) begin
            bus.rt_o = bus.ex_result_i;
            bus.fwd_rt_sel_o = 2'd1;
        end else if (rt_wb) begin
            bus.rt_o = bus.wb_result_i;
            bus.fwd_rt_sel_o = 2'd2;
        end else if (rt_h) begin
            bus.rt_o = hist_data;
            bus.fwd_rt_sel_o = 2'd3;
        end
    end

    always_comb begin
        nxt = state;
        if (bus.branch_taken_i) begin
            nxt = FLUSH1;
        end else begin
            unique case (state)
                IDLE:    if (load_use) nxt = STALL;
                STALL:   nxt = IDLE;
                FLUSH1:  nxt = FLUSH2;
                FLUSH2:  nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            flush_q   <= 1'b0;
            hist_v    <= 1'b0;
            hist_rd   <= '0;
            hist_data <= '0;
        end else begin
            state     <= nxt;
            flush_q   <= (nxt == FLUSH1) || (nxt == FLUSH2);
            hist_v    <= wb_src;
            hist_rd   <= bus.wb_rd_i;
            hist_data <= bus.wb_result_i;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (bus.branch_taken_i && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed cases plus random
// traffic against a behavioural model of forwarding, stall and flush.
module tb_hazard_fwd_unit;
    localparam int D = 32;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.D(D), .R(R)) bus ();

    hazard_fwd_unit #(.D(D), .R(R)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model: cycles of flush left, whether a stall was just taken, last WB write.
    int           flush_rem;
    bit           stall_pend;
    bit           h_v;
    logic [R-1:0] h_rd;
    logic [D-1:0] h_data;
    int           m_scnt;
    int           m_fcnt;

    logic [D-1:0] c_v;
    logic [1:0]   c_s;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit ex_writes(input logic [R-1:0] a);
        return a != 0 && bus.ex_valid_i && bus.ex_we_i && bus.ex_rd_i == a;
    endfunction

    function automatic bit lu();
        return bus.dec_valid_i && bus.ex_is_load_i &&
               (ex_writes(bus.dec_rs_addr_i) || ex_writes(bus.dec_rt_addr_i));
    endfunction

    function automatic bit exp_stall();
        return rst_n && flush_rem == 0 && !stall_pend && lu() &&
               !bus.branch_taken_i;
    endfunction

    function automatic void exp_op(input logic [R-1:0] a,
                                   input logic [D-1:0] rf,
                                   output logic [D-1:0] v,
                                   output logic [1:0] s);
        bit           hit [3];
        logic [D-1:0] val [3];
        hit[0] = ex_writes(a) && !bus.ex_is_load_i;
        val[0] = bus.ex_result_i;
        hit[1] = bus.wb_valid_i && bus.wb_we_i && bus.wb_rd_i == a;
        val[1] = bus.wb_result_i;
        hit[2] = h_v && h_rd == a;
        val[2] = h_data;
        v = rf;
        s = 2'd0;
        if (a != 0)
            for (int i = 2; i >= 0; i--)
                if (hit[i]) begin
                    v = val[i];
                    s = 2'(i + 1);
                end
    endfunction

    task automatic model_reset();
        flush_rem = 0;
        stall_pend = 0;
        h_v = 0;
        h_rd = '0;
        h_data = '0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (exp_stall() && m_scnt < 65535) m_scnt++;
        if (bus.branch_taken_i && m_fcnt < 65535) m_fcnt++;
        if (bus.branch_taken_i) begin
            flush_rem = 2;
            stall_pend = 0;
        end else if (flush_rem > 0) begin
            flush_rem--;
            stall_pend = 0;
        end else if (stall_pend) begin
            stall_pend = 0;
        end else begin
            stall_pend = lu();
        end
        h_v = bus.wb_valid_i && bus.wb_we_i;
        h_rd = bus.wb_rd_i;
        h_data = bus.wb_result_i;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        bus.dec_valid_i = 0;
        bus.dec_rs_addr_i = '0;
        bus.dec_rt_addr_i = '0;
        bus.dec_rs_i = '0;
        bus.dec_rt_i = '0;
        bus.ex_valid_i = 0;
        bus.ex_we_i = 0;
        bus.ex_is_load_i = 0;
        bus.ex_rd_i = '0;
        bus.ex_result_i = '0;
        bus.wb_valid_i = 0;
        bus.wb_we_i = 0;
        bus.wb_rd_i = '0;
        bus.wb_result_i = '0;
        bus.branch_taken_i = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            exp_op(bus.dec_rs_addr_i, bus.dec_rs_i, c_v, c_s);
            chk("rs_o", 64'(bus.rs_o), 64'(c_v));
            chk("rs_sel", 64'(bus.fwd_rs_sel_o), 64'(c_s));
            exp_op(bus.dec_rt_addr_i, bus.dec_rt_i, c_v, c_s);
            chk("rt_o", 64'(bus.rt_o), 64'(c_v));
            chk("rt_sel", 64'(bus.fwd_rt_sel_o), 64'(c_s));
            chk("stall", 64'(bus.stall_o), 64'(exp_stall()));
            chk("flush", 64'(bus.flush_o), 64'(rst_n && flush_rem > 0));
`ifdef HAZARD_PERF_EN
            chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_scnt));
            chk("flush_cnt", 64'(bus.flush_cnt_o), 64'(m_fcnt));
`endif
        end
    end

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        chk_en = 1;
        bus.dec_rs_i = 32'h5A5A;
        #3;
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_flush", 64'(bus.flush_o), 64'd0);
        chk("rst_rs_sel", 64'(bus.fwd_rs_sel_o), 64'd0);
        chk("rst_rs_o", 64'(bus.rs_o), 64'h5A5A);
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_rd_i = 5'd2;
        bus.ex_result_i = 32'h77;
        bus.dec_rs_addr_i = 5'd2;
        #1;
        chk("rst_ex_rs_o", 64'(bus.rs_o), 64'h77);
        chk("rst_ex_sel", 64'(bus.fwd_rs_sel_o), 64'd1);
        tick();
        rst_n = 1;

        clear_inputs();
        bus.dec_valid_i = 1;
        bus.dec_rs_addr_i = 5'd3;
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_rd_i = 5'd3;
        bus.ex_result_i = 32'h11;
        settle();
        chk("ex_fwd_rs_o", 64'(bus.rs_o), 64'h11);
        chk("ex_fwd_sel", 64'(bus.fwd_rs_sel_o), 64'd1);
        chk("ex_fwd_stall", 64'(bus.stall_o), 64'd0);

        tick();
        clear_inputs();
        bus.dec_valid_i = 1;
        bus.dec_rt_addr_i = 5'd5;
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_rd_i = 5'd5;
        bus.ex_result_i = 32'hAA;
        bus.wb_valid_i = 1;
        bus.wb_we_i = 1;
        bus.wb_rd_i = 5'd5;
        bus.wb_result_i = 32'hBB;
        settle();
        chk("prio_rt_o", 64'(bus.rt_o), 64'hAA);
        chk("prio_rt_sel", 64'(bus.fwd_rt_sel_o), 64'd1);

        tick();
        clear_inputs();
        bus.dec_valid_i = 1;
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_rd_i = 5'd0;
        bus.ex_result_i = 32'hFF;
        settle();
        chk("r0_rs_o", 64'(bus.rs_o), 64'd0);
        chk("r0_sel", 64'(bus.fwd_rs_sel_o), 64'd0);

        tick();
        clear_inputs();
        bus.dec_valid_i = 1;
        bus.dec_rs_addr_i = 5'd7;
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_is_load_i = 1;
        bus.ex_rd_i = 5'd7;
        bus.ex_result_i = 32'hDEAD;
        settle();
        chk("lu_stall", 64'(bus.stall_o), 64'd1);
        chk("lu_no_ex_sel", 64'(bus.fwd_rs_sel_o), 64'd0);
        tick();
        clear_inputs();
        bus.dec_valid_i = 1;
        bus.dec_rs_addr_i = 5'd7;
        bus.wb_valid_i = 1;
        bus.wb_we_i = 1;
        bus.wb_rd_i = 5'd7;
        bus.wb_result_i = 32'h1234;
        settle();
        chk("lu_wb_rs_o", 64'(bus.rs_o), 64'h1234);
        chk("lu_wb_sel", 64'(bus.fwd_rs_sel_o), 64'd2);
        chk("lu_stall_done", 64'(bus.stall_o), 64'd0);

        tick();
        clear_inputs();
        bus.branch_taken_i = 1;
        bus.dec_valid_i = 1;
        bus.dec_rs_addr_i = 5'd4;
        bus.ex_valid_i = 1;
        bus.ex_we_i = 1;
        bus.ex_is_load_i = 1;
        bus.ex_rd_i = 5'd4;
        settle();
        chk("br_lu_stall", 64'(bus.stall_o), 64'd0);
        chk("br_lu_flush0", 64'(bus.flush_o), 64'd0);
        tick();
        clear_inputs();
        settle();
        chk("br_flush1", 64'(bus.flush_o), 64'd1);
        tick();
        settle();
        chk("br_flush2", 64'(bus.flush_o), 64'd1);
        tick();
        settle();
        chk("br_idle", 64'(bus.flush_o), 64'd0);

        tick();
        clear_inputs();
        bus.branch_taken_i = 1;
        bus.wb_valid_i = 1;
        bus.wb_we_i = 1;
        bus.wb_rd_i = 5'd9;
        bus.wb_result_i = 32'h99;
        tick();
        clear_inputs();
        bus.dec_rs_addr_i = 5'd9;
        bus.dec_rs_i = 32'h1;
        settle();
        chk("f1_flush", 64'(bus.flush_o), 64'd1);
        chk("f1_hist_rs_o", 64'(bus.rs_o), 64'h99);
        chk("f1_hist_sel", 64'(bus.fwd_rs_sel_o), 64'd3);
        rst_n = 0;
        model_reset();
        #1;
        chk("f1_rst_flush", 64'(bus.flush_o), 64'd0);
        chk("f1_rst_sel", 64'(bus.fwd_rs_sel_o), 64'd0);
        chk("f1_rst_rs_o", 64'(bus.rs_o), 64'h1);
`ifdef HAZARD_PERF_EN
        chk("f1_rst_scnt", 64'(bus.stall_cnt_o), 64'd0);
        chk("f1_rst_fcnt", 64'(bus.flush_cnt_o), 64'd0);
`endif
        tick();
        rst_n = 1;

        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!rst_n) begin
                rst_n = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                model_reset();
            end
            bus.dec_valid_i = ($urandom_range(0, 7) != 0);
            bus.dec_rs_addr_i = R'($urandom_range(0, 3));
            bus.dec_rt_addr_i = R'($urandom_range(0, 3));
            bus.dec_rs_i = $urandom;
            bus.dec_rt_i = $urandom;
            bus.ex_valid_i = ($urandom_range(0, 3) != 0);
            bus.ex_we_i = ($urandom_range(0, 3) != 0);
            bus.ex_is_load_i = ($urandom_range(0, 2) == 0);
            bus.ex_rd_i = R'($urandom_range(0, 3));
            bus.ex_result_i = $urandom;
            bus.wb_valid_i = ($urandom_range(0, 3) != 0);
            bus.wb_we_i = ($urandom_range(0, 3) != 0);
            bus.wb_rd_i = R'($urandom_range(0, 3));
            bus.wb_result_i = $urandom;
            bus.branch_taken_i = ($urandom_range(0, 7) == 0);
        end

        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
